// File: rtl/excp_ctrl_pkg.sv
// Shared exception/CSR definitions for the commit sequencer: exception codes,
// FSM encodings, CSR numbers and the WB event classifier.
package excp_ctrl_pkg;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  localparam logic [8:0] ESUBCODE_ADEF = 9'd0;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_REDIR = 2'd1,
    ST_DRAIN = 2'd2
  } excp_state_e;

  typedef struct packed {
    logic take_ex;
    logic take_int;
    logic take_ertn;
    logic plain;
  } wb_evt_t;

  // Exception beats interrupt beats ertn; anything else retires normally.
  function automatic wb_evt_t classify(input logic go, input logic ex,
                                       input logic intr, input logic ertn);
    wb_evt_t e;
    e.take_ex   = go & ex;
    e.take_int  = go & ~ex & intr;
    e.take_ertn = go & ~ex & ~intr & ertn;
    e.plain     = go & ~ex & ~intr & ~ertn;
    return e;
  endfunction

endpackage

// File: rtl/excp_ctrl.sv
// Exception/interrupt commit sequencer: qualifies the retiring WB instruction,
// strobes the CSR file, then runs redirect handshake and flush drain.
module excp_ctrl
  import excp_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        wb_ertn,
  input  logic        wb_csr_we,
  input  logic [13:0] wb_csr_num,
  input  logic [31:0] wb_csr_wmask,
  input  logic [31:0] wb_csr_wvalue,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ex_epc,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        csr_wb_ex,
  output logic        csr_ertn_flush,
  output logic [5:0]  csr_ecode,
  output logic [8:0]  csr_esubcode,
  output logic [31:0] csr_pc,
  output logic [31:0] csr_vaddr,
  output logic        wb_ready,
  output logic        wb_commit,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES);

  excp_state_e state, nxt_state;
  logic [31:0] tgt, nxt_tgt;
  logic [3:0]  cnt, nxt_cnt;
  wb_evt_t     evt;

  assign wb_ready = (state == ST_RUN);
  assign evt      = classify(wb_valid & wb_ready, wb_ex, has_int, wb_ertn);

  // CSR-side strobes; an interrupt rides on the WB instruction with code 0.
  assign csr_wb_ex      = evt.take_ex | evt.take_int;
  assign csr_ertn_flush = evt.take_ertn;
  assign csr_ecode      = evt.take_ex ? wb_ecode    : ECODE_INT;
  assign csr_esubcode   = evt.take_ex ? wb_esubcode : 9'd0;
  assign csr_pc         = wb_pc;
  assign csr_vaddr      = wb_vaddr;
  assign csr_we         = evt.plain & wb_csr_we;
  assign csr_num        = wb_csr_num;
  assign csr_wmask      = wb_csr_wmask;
  assign csr_wvalue     = wb_csr_wvalue;
  assign wb_commit      = evt.plain;

  assign flush          = (state != ST_RUN);
  assign redirect_valid = (state == ST_REDIR);
  assign redirect_pc    = tgt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_RUN;
      tgt   <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      tgt   <= nxt_tgt;
      cnt   <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_tgt   = tgt;
    nxt_cnt   = cnt;
    unique case (state)
      ST_RUN: begin
        // Target sampled before the CSR file commits this cycle's update.
        if (evt.take_ex | evt.take_int) begin
          nxt_tgt   = ex_entry;
          nxt_state = ST_REDIR;
        end else if (evt.take_ertn) begin
          nxt_tgt   = ex_epc;
          nxt_state = ST_REDIR;
        end
      end
      ST_REDIR: begin
        if (redirect_ready) begin
          nxt_cnt   = DRAIN_LOAD;
          nxt_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt <= 4'd1) begin
          nxt_cnt   = '0;
          nxt_state = ST_RUN;
        end else begin
          nxt_cnt = cnt - 4'd1;
        end
      end
      default: begin
        nxt_state = ST_RUN;
        nxt_cnt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_excp_ctrl.sv
// Scoreboard bench for excp_ctrl: per-cycle CSR strobe expectations and
// expected redirect targets are queued at drive time and checked on output.
module tb_excp_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid, wb_ex, wb_ertn, wb_csr_we, has_int;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr, wb_csr_wmask, wb_csr_wvalue, ex_entry, ex_epc;
  logic [13:0] wb_csr_num;
  logic        csr_we, csr_wb_ex, csr_ertn_flush, wb_ready, wb_commit;
  logic        flush, redirect_valid, redirect_ready;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue, csr_pc, csr_vaddr, redirect_pc;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;

  excp_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .resetn(resetn),
    .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .wb_ertn(wb_ertn), .wb_csr_we(wb_csr_we), .wb_csr_num(wb_csr_num),
    .wb_csr_wmask(wb_csr_wmask), .wb_csr_wvalue(wb_csr_wvalue),
    .has_int(has_int), .ex_entry(ex_entry), .ex_epc(ex_epc),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .csr_wb_ex(csr_wb_ex),
    .csr_ertn_flush(csr_ertn_flush), .csr_ecode(csr_ecode),
    .csr_esubcode(csr_esubcode), .csr_pc(csr_pc), .csr_vaddr(csr_vaddr),
    .wb_ready(wb_ready), .wb_commit(wb_commit), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wbex;
    logic        ertn;
    logic        we;
    logic        commit;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] pc;
    logic [13:0] num;
  } strb_t;

  strb_t       strb_q[$];
  logic [31:0] redir_q[$];
  strb_t       mon_e;
  logic [31:0] mon_pc;
  int          n_chk = 0;
  int          n_fail = 0;
  int          flush_hi = 0;

  always @(negedge clk) if (flush) flush_hi++;

  // Strobe scoreboard: one expectation per driven cycle.
  always @(negedge clk) begin
    if (strb_q.size() > 0) begin
      mon_e = strb_q.pop_front();
      n_chk++; if (csr_wb_ex !== mon_e.wbex) begin n_fail++; $display("FAIL csr_wb_ex @%0t: got %0b expected %0b", $time, csr_wb_ex, mon_e.wbex); end
      n_chk++; if (csr_ertn_flush !== mon_e.ertn) begin n_fail++; $display("FAIL csr_ertn_flush @%0t: got %0b expected %0b", $time, csr_ertn_flush, mon_e.ertn); end
      n_chk++; if (csr_we !== mon_e.we) begin n_fail++; $display("FAIL csr_we @%0t: got %0b expected %0b", $time, csr_we, mon_e.we); end
      n_chk++; if (wb_commit !== mon_e.commit) begin n_fail++; $display("FAIL wb_commit @%0t: got %0b expected %0b", $time, wb_commit, mon_e.commit); end
      n_chk++; if (csr_ecode !== mon_e.ecode) begin n_fail++; $display("FAIL csr_ecode @%0t: got %0h expected %0h", $time, csr_ecode, mon_e.ecode); end
      n_chk++; if (csr_esubcode !== mon_e.esub) begin n_fail++; $display("FAIL csr_esubcode @%0t: got %0h expected %0h", $time, csr_esubcode, mon_e.esub); end
      n_chk++; if (csr_pc !== mon_e.pc) begin n_fail++; $display("FAIL csr_pc @%0t: got %0h expected %0h", $time, csr_pc, mon_e.pc); end
      n_chk++; if (csr_num !== mon_e.num) begin n_fail++; $display("FAIL csr_num @%0t: got %0h expected %0h", $time, csr_num, mon_e.num); end
    end
  end

  // Redirect scoreboard: popped on every handshake.
  always @(negedge clk) begin
    if (resetn && redirect_valid && redirect_ready) begin
      n_chk++;
      if (redir_q.size() == 0) begin
        n_fail++; $display("FAIL redirect_unexpected @%0t: got pc %0h expected no redirect", $time, redirect_pc);
      end else begin
        mon_pc = redir_q.pop_front();
        if (redirect_pc !== mon_pc) begin n_fail++; $display("FAIL redirect_pc @%0t: got %0h expected %0h", $time, redirect_pc, mon_pc); end
      end
    end
  end

  // Drive one WB cycle, queue its expected strobes, advance past the edge.
  task automatic drive(input logic v, input logic ex, input logic intr,
                       input logic ertn, input logic we, input logic [5:0] ec,
                       input logic [31:0] pc, input bit run);
    strb_t e;
    logic go, tex, tint, tert, pl;
    wb_valid = v; wb_ex = ex; has_int = intr; wb_ertn = ertn; wb_csr_we = we;
    wb_ecode = ec; wb_pc = pc; wb_vaddr = pc ^ 32'hFFFF_0000;
    go   = v & run;
    tex  = go & ex;
    tint = go & ~ex & intr;
    tert = go & ~ex & ~intr & ertn;
    pl   = go & ~ex & ~intr & ~ertn;
    e.wbex = tex | tint; e.ertn = tert; e.we = pl & we; e.commit = pl;
    e.ecode = tex ? ec : 6'h00; e.esub = tex ? wb_esubcode : 9'd0;
    e.pc = pc; e.num = wb_csr_num;
    strb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; redirect_ready = 1'b1;
    wb_valid = 0; wb_ex = 0; wb_ertn = 0; wb_csr_we = 0; has_int = 0;
    wb_ecode = 0; wb_esubcode = 9'h1A5; wb_pc = 0; wb_vaddr = 0;
    wb_csr_num = 14'h030; wb_csr_wmask = 32'hFFFF_FFFF; wb_csr_wvalue = 32'h1234_5678;
    ex_entry = 32'h1C00_8000; ex_epc = 32'h0;
    #1;
    n_chk++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %0b expected 0", flush); end
    n_chk++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_valid: got %0b expected 0", redirect_valid); end
    n_chk++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc: got %0h expected 0", redirect_pc); end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    n_chk++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb_ready: got %0b expected 1", wb_ready); end
    drive(1, 0, 0, 0, 1, 6'h00, 32'h1C00_0000, 1);
  endtask

  task automatic test_exception();
    redirect_ready = 1'b1; ex_entry = 32'h1C00_8000;
    redir_q.push_back(32'h1C00_8000);
    flush_hi = 0;
    drive(1, 1, 0, 0, 0, 6'h0B, 32'h1C00_0100, 1);
    // WB keeps presenting instructions; none may strobe or commit.
    for (int i = 0; i < 1 + FC; i++) drive(1, 0, 0, 0, 1, 6'h00, 32'h1C00_0104, 0);
    n_chk++; if (flush_hi !== 1 + FC) begin n_fail++; $display("FAIL ex_flush_cycles: got %0d expected %0d", flush_hi, 1 + FC); end
    n_chk++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL ex_back_to_run: got %0b expected 1", wb_ready); end
    drive(1, 0, 0, 0, 1, 6'h00, 32'h1C00_0104, 1);
  endtask

  task automatic test_interrupt();
    ex_entry = 32'h1C00_9000;
    redir_q.push_back(32'h1C00_9000);
    flush_hi = 0;
    drive(1, 0, 1, 0, 1, 6'h0D, 32'h1C00_0200, 1);
    for (int i = 0; i < 1 + FC; i++) drive(0, 0, 0, 0, 0, 6'h00, 32'h0, 0);
    n_chk++; if (flush_hi !== 1 + FC) begin n_fail++; $display("FAIL int_flush_cycles: got %0d expected %0d", flush_hi, 1 + FC); end
  endtask

  task automatic test_priority();
    // Exception beats interrupt and ertn; interrupt beats ertn.
    ex_entry = 32'h1C00_A000; ex_epc = 32'h1C00_0F00;
    redir_q.push_back(32'h1C00_A000);
    drive(1, 1, 1, 1, 1, 6'h0D, 32'h1C00_0300, 1);
    for (int i = 0; i < 1 + FC; i++) drive(1, 1, 1, 1, 1, 6'h0D, 32'h1C00_0300, 0);
    redir_q.push_back(32'h1C00_A000);
    drive(1, 0, 1, 1, 0, 6'h00, 32'h1C00_0304, 1);
    for (int i = 0; i < 1 + FC; i++) drive(0, 0, 0, 0, 0, 6'h00, 32'h0, 0);
    has_int = 0;
  endtask

  task automatic test_ertn_stall();
    logic [31:0] pc0;
    redirect_ready = 1'b0; ex_epc = 32'h1C00_0204; ex_entry = 32'h1C00_8000;
    redir_q.push_back(32'h1C00_0204);
    flush_hi = 0;
    drive(1, 0, 0, 1, 0, 6'h00, 32'h1C00_0400, 1);
    ex_epc = 32'hDEAD_0000;
    pc0 = 32'h1C00_0204;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %0b expected 1", i, redirect_valid); end
      n_chk++; if (redirect_pc !== pc0) begin n_fail++; $display("FAIL stall_pc[%0d]: got %0h expected %0h", i, redirect_pc, pc0); end
      n_chk++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL stall_wb_ready[%0d]: got %0b expected 0", i, wb_ready); end
      drive(1, 0, 0, 1, 1, 6'h00, 32'h1C00_0404, 0);
    end
    redirect_ready = 1'b1;
    drive(1, 0, 0, 0, 1, 6'h00, 32'h1C00_0404, 0);
    for (int i = 0; i < FC; i++) begin
      n_chk++; if (flush !== 1'b1 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL drain[%0d]: got flush %0b valid %0b expected 1 0", i, flush, redirect_valid); end
      drive(1, 0, 0, 0, 1, 6'h00, 32'h1C00_0404, 0);
    end
    n_chk++; if (flush_hi !== 6 + FC) begin n_fail++; $display("FAIL stall_flush_cycles: got %0d expected %0d", flush_hi, 6 + FC); end
    drive(1, 0, 0, 0, 1, 6'h00, 32'h1C00_0404, 1);
  endtask

  task automatic test_reset_mid_drain();
    redirect_ready = 1'b1; ex_entry = 32'h1C00_B000;
    redir_q.push_back(32'h1C00_B000);
    drive(1, 1, 0, 0, 0, 6'h0C, 32'h1C00_0500, 1);
    drive(0, 0, 0, 0, 0, 6'h00, 32'h0, 0);
    n_chk++; if (flush !== 1'b1) begin n_fail++; $display("FAIL pre_reset_flush: got %0b expected 1", flush); end
    resetn = 1'b0;
    #1;
    n_chk++; if (flush !== 1'b0) begin n_fail++; $display("FAIL async_flush: got %0b expected 0", flush); end
    n_chk++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %0b expected 0", redirect_valid); end
    n_chk++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL async_redirect_pc: got %0h expected 0", redirect_pc); end
    @(posedge clk); #1 resetn = 1'b1;
    #1;
    n_chk++; if (wb_ready !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL post_reset: got ready %0b flush %0b expected 1 0", wb_ready, flush); end
    drive(1, 0, 0, 0, 1, 6'h00, 32'h1C00_0600, 1);
    drive(0, 0, 0, 0, 0, 6'h00, 32'h0, 1);
  endtask

  initial begin
    test_reset();
    test_exception();
    test_interrupt();
    test_priority();
    test_ertn_stall();
    test_reset_mid_drain();
    @(negedge clk); #1;
    n_chk++; if (strb_q.size() != 0) begin n_fail++; $display("FAIL strobe_queue_left: got %0d expected 0", strb_q.size()); end
    n_chk++; if (redir_q.size() != 0) begin n_fail++; $display("FAIL redirect_queue_left: got %0d expected 0", redir_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
